// File: rtl/taxi_pkg.sv
// Shared Taxi-environment constants: grid/location/destination counts, field widths,
// passenger depot codes and a state-space size helper.
package taxi_pkg;

  localparam int unsigned GRID_ROWS    = 5;
  localparam int unsigned GRID_COLS    = 5;
  localparam int unsigned NUM_PASS_LOC = 5;
  localparam int unsigned NUM_DEST     = 4;
  localparam int unsigned STATE_W      = 9;

  localparam int unsigned ROW_W  = 3;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned LOC_W  = 3;
  localparam int unsigned DEST_W = 2;

  typedef enum logic [LOC_W-1:0] {
    LOC_R       = 3'd0,
    LOC_G       = 3'd1,
    LOC_Y       = 3'd2,
    LOC_B       = 3'd3,
    LOC_IN_TAXI = 3'd4
  } pass_loc_e;

  function automatic longint unsigned state_count(input int unsigned rows,
                                                  input int unsigned cols,
                                                  input int unsigned locs,
                                                  input int unsigned dests);
    return 64'(rows) * 64'(cols) * 64'(locs) * 64'(dests);
  endfunction

endpackage

// File: rtl/taxi_state_encoder_if.sv
// Observation-in / encoded-state-out bundle between the env model and Q-table addressing.
interface taxi_state_encoder_if
  import taxi_pkg::*;
#(
  parameter int unsigned STATE_W = taxi_pkg::STATE_W
);

  logic               in_valid;
  logic [ROW_W-1:0]   taxi_row;
  logic [COL_W-1:0]   taxi_col;
  logic [LOC_W-1:0]   pass_loc;
  logic [DEST_W-1:0]  dest_idx;
  logic               out_valid;
  logic [STATE_W-1:0] encoded_state;
  logic               range_err;

  modport master (
    output in_valid, taxi_row, taxi_col, pass_loc, dest_idx,
    input  out_valid, encoded_state, range_err
  );

  modport slave (
    input  in_valid, taxi_row, taxi_col, pass_loc, dest_idx,
    output out_valid, encoded_state, range_err
  );

endinterface

// File: rtl/taxi_state_index.sv
// Combinational flat-index calculation with range flag; out-of-range samples yield index 0.
module taxi_state_index
  import taxi_pkg::*;
#(
  parameter int unsigned GRID_ROWS    = taxi_pkg::GRID_ROWS,
  parameter int unsigned GRID_COLS    = taxi_pkg::GRID_COLS,
  parameter int unsigned NUM_PASS_LOC = taxi_pkg::NUM_PASS_LOC,
  parameter int unsigned NUM_DEST     = taxi_pkg::NUM_DEST,
  parameter int unsigned STATE_W      = taxi_pkg::STATE_W
) (
  input  logic [ROW_W-1:0]   taxi_row,
  input  logic [COL_W-1:0]   taxi_col,
  input  logic [LOC_W-1:0]   pass_loc,
  input  logic [DEST_W-1:0]  dest_idx,
  output logic [STATE_W-1:0] state_index,
  output logic               range_err
);

  // One spare bit so no partial product is truncated before the final result.
  localparam int unsigned CALC_W = STATE_W + 1;

  logic [CALC_W-1:0] cell_idx;
  logic [CALC_W-1:0] loc_idx;
  logic [CALC_W-1:0] full_idx;

  always_comb begin
    cell_idx = CALC_W'(taxi_row) * CALC_W'(GRID_COLS) + CALC_W'(taxi_col);
    loc_idx  = cell_idx * CALC_W'(NUM_PASS_LOC) + CALC_W'(pass_loc);
    full_idx = loc_idx * CALC_W'(NUM_DEST) + CALC_W'(dest_idx);
  end

  always_comb begin
    range_err = (32'(taxi_row) >= GRID_ROWS)    ||
                (32'(taxi_col) >= GRID_COLS)    ||
                (32'(pass_loc) >= NUM_PASS_LOC) ||
                (32'(dest_idx) >= NUM_DEST);
    state_index = range_err ? '0 : STATE_W'(full_idx);
  end

endmodule

// File: rtl/taxi_state_encoder.sv
// Registered, valid-qualified Taxi observation -> flat Q-table state index encoder (1-cycle latency).
module taxi_state_encoder
  import taxi_pkg::*;
#(
  parameter int unsigned GRID_ROWS    = taxi_pkg::GRID_ROWS,
  parameter int unsigned GRID_COLS    = taxi_pkg::GRID_COLS,
  parameter int unsigned NUM_PASS_LOC = taxi_pkg::NUM_PASS_LOC,
  parameter int unsigned NUM_DEST     = taxi_pkg::NUM_DEST,
  parameter int unsigned STATE_W      = taxi_pkg::STATE_W
) (
  input logic                 clk,
  input logic                 rst,
  taxi_state_encoder_if.slave bus
);

  if ((64'(1) << STATE_W) < state_count(GRID_ROWS, GRID_COLS, NUM_PASS_LOC, NUM_DEST))
  begin : g_state_w_too_small
    $error("taxi_state_encoder: STATE_W too small for the configured state space");
  end

  logic [STATE_W-1:0] next_index;
  logic               next_err;

  taxi_state_index #(
    .GRID_ROWS    (GRID_ROWS),
    .GRID_COLS    (GRID_COLS),
    .NUM_PASS_LOC (NUM_PASS_LOC),
    .NUM_DEST     (NUM_DEST),
    .STATE_W      (STATE_W)
  ) u_index (
    .taxi_row    (bus.taxi_row),
    .taxi_col    (bus.taxi_col),
    .pass_loc    (bus.pass_loc),
    .dest_idx    (bus.dest_idx),
    .state_index (next_index),
    .range_err   (next_err)
  );

  // Result registers hold their last value while no sample is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.encoded_state <= '0;
      bus.range_err     <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.encoded_state <= next_index;
        bus.range_err     <= next_err;
      end
    end
  end

endmodule

// File: tb/tb_taxi_state_encoder.sv
// Self-checking bench for taxi_state_encoder: reference model checked every cycle plus literal vectors.
module tb_taxi_state_encoder;

  logic clk;
  logic rst;

  int unsigned n_cmp  = 0;
  int unsigned n_miss = 0;

  taxi_state_encoder_if #(.STATE_W(9)) bus ();

  taxi_state_encoder #(
    .GRID_ROWS    (5),
    .GRID_COLS    (5),
    .NUM_PASS_LOC (5),
    .NUM_DEST     (4),
    .STATE_W      (9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 100 states per row, 20 per column, 4 per passenger location.
  int  m_state = 0;
  bit  m_valid = 0;
  bit  m_err   = 0;

  function automatic bit model_err(int r, int c, int p, int d);
    return (r > 4) || (c > 4) || (p > 4) || (d > 3);
  endfunction

  function automatic int model_state(int r, int c, int p, int d);
    if (model_err(r, c, p, d)) return 0;
    return r * 100 + c * 20 + p * 4 + d;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0;
      m_state = 0;
      m_err   = 0;
    end else begin
      m_valid = bus.in_valid;
      if (bus.in_valid) begin
        m_state = model_state(int'(bus.taxi_row), int'(bus.taxi_col),
                              int'(bus.pass_loc), int'(bus.dest_idx));
        m_err   = model_err(int'(bus.taxi_row), int'(bus.taxi_col),
                            int'(bus.pass_loc), int'(bus.dest_idx));
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_out_valid", int'(bus.out_valid), int'(m_valid));
    check("model_encoded_state", int'(bus.encoded_state), m_state);
    check("model_range_err", int'(bus.range_err), int'(m_err));
  end

  task automatic drive(input bit v, input int r, input int c, input int p, input int d);
    bus.in_valid = v;
    bus.taxi_row = 3'(r);
    bus.taxi_col = 3'(c);
    bus.pass_loc = 3'(p);
    bus.dest_idx = 2'(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input bit v, input int s, input bit e);
    check({name, "_valid"}, int'(bus.out_valid), int'(v));
    check({name, "_state"}, int'(bus.encoded_state), s);
    check({name, "_err"}, int'(bus.range_err), int'(e));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check_lit("reset", 0, 0, 0);
    rst = 1'b0;
    tick();
    check_lit("idle_after_reset", 0, 0, 0);

    drive(1, 1, 0, 2, 3); tick(); check_lit("vec_111", 1, 111, 0);
    drive(1, 0, 0, 0, 0); tick(); check_lit("vec_zero", 1, 0, 0);
    drive(1, 4, 4, 4, 3); tick(); check_lit("vec_max", 1, 499, 0);
    drive(1, 2, 3, 4, 1); tick(); check_lit("vec_277", 1, 277, 0);
    drive(1, 5, 1, 1, 1); tick(); check_lit("row_oor", 1, 0, 1);
    drive(1, 1, 1, 7, 1); tick(); check_lit("pass_oor", 1, 0, 1);
    drive(1, 0, 5, 0, 0); tick(); check_lit("col_oor", 1, 0, 1);

    // Back-to-back stream, then valid dropped with garbage on the data lines.
    drive(1, 1, 0, 2, 3); tick(); check_lit("b2b_111", 1, 111, 0);
    drive(1, 4, 4, 4, 3); tick(); check_lit("b2b_499", 1, 499, 0);
    drive(1, 0, 0, 0, 0); tick(); check_lit("b2b_0", 1, 0, 0);
    drive(1, 1, 0, 2, 3); tick(); check_lit("pre_drop", 1, 111, 0);
    drive(0, 7, 7, 7, 3); tick(); check_lit("drop_hold", 0, 111, 0);
    tick();                       check_lit("drop_hold2", 0, 111, 0);
    drive(0, 5, 0, 0, 0); tick(); check_lit("err_hold_pre", 0, 111, 0);
    drive(1, 6, 0, 0, 0); tick(); check_lit("err_set", 1, 0, 1);
    drive(0, 0, 0, 0, 0); tick(); check_lit("err_hold", 0, 0, 1);

    // Mid-stream reset between edges with a sample in flight.
    drive(1, 2, 3, 4, 1); tick(); check_lit("pre_rst", 1, 277, 0);
    drive(1, 4, 4, 4, 3);
    #2;
    rst = 1'b1;
    #1;
    check_lit("rst_async", 0, 0, 0);
    tick();
    check_lit("rst_held", 0, 0, 0);
    drive(0, 4, 4, 4, 3);
    rst = 1'b0;
    tick();
    check_lit("post_rst_no_stale", 0, 0, 0);
    drive(1, 1, 0, 2, 3); tick(); check_lit("post_rst_first", 1, 111, 0);

    // Model-checked sweep mixing legal, illegal and idle cycles.
    for (int i = 0; i < 60; i++) begin
      drive(bit'((i % 5) != 4), (i * 3) % 7, (i * 5) % 6, (i * 7) % 8, i % 4);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
